uart_frame_scheduler: RTL

Sequences demodulated radiometer samples onto the UART transmitter. It sits between the ADC demodulation path and the byte-wide UART transmitter. It buffers 12-bit demodulated samples in a small FIFO and assembles them into fixed-length frames: sync byte, sequence byte, sample bytes, then an optional checksum. It issues one byte at a time to the transmitter using the transmitter's enable/busy handshake.

---
 rtl/radiometer_pkg.sv | 27 ++
 rtl/uart_frame_scheduler_if.sv | 25 ++
 rtl/uart_frame_scheduler_sample_fifo.sv | 57 +++++
 rtl/uart_frame_scheduler.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/radiometer_pkg.sv
// Shared types and constants for the radiometer UART framing path.
// Build option: FRAME_CHECKSUM_EN adds the CSUM state to the frame FSM.
package radiometer_pkg;

  localparam int BYTE_W   = 8;
  localparam int SAMPLE_W = 12;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_HI,
    ST_LO,
`ifdef FRAME_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_WAIT
  } state_t;

  // Upper nibble of a sample, zero-extended to a byte.
  function automatic logic [BYTE_W-1:0] sample_hi_byte(input logic [SAMPLE_W-1:0] s);
    return {4'h0, s[SAMPLE_W-1:BYTE_W]};
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Sample-in / UART-byte-out bundle of the frame scheduler.
// master = scheduler side, slave = surrounding logic (demod, UART, switch).
interface uart_frame_scheduler_if;
  import radiometer_pkg::*;

  logic                enable;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                uart_busy;
  logic                uart_tx_en;
  logic [BYTE_W-1:0]   uart_tx_data;
  logic                frame_active;
  logic                overrun;

  modport master (
    input  enable, sample_valid, sample, uart_busy,
    output uart_tx_en, uart_tx_data, frame_active, overrun
  );

  modport slave (
    output enable, sample_valid, sample, uart_busy,
    input  uart_tx_en, uart_tx_data, frame_active, overrun
  );

endinterface

// File: rtl/uart_frame_scheduler_sample_fifo.sv
// Synchronous show-ahead FIFO for demodulated samples; the head is always
// visible on o_head. A push while full is accepted only if a pop happens too.
module sample_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // NOTE: storage has no reset; pointers and count define validity, and an
  // unreset array maps onto plain RAM/LUT-RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Frames buffered samples as SYNC, seq, {hi, lo} x N [, checksum] for a
// byte-wide UART. Build option: FRAME_CHECKSUM_EN appends an XOR checksum.
module uart_frame_scheduler
  import radiometer_pkg::*;
#(
  parameter int                SAMPLES_PER_FRAME = 4,
  parameter int                FIFO_DEPTH        = 8,
  parameter logic [BYTE_W-1:0] SYNC_BYTE         = SYNC_BYTE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_frame_scheduler_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t              r_state;
  state_t              w_next_state;
  state_t              r_ret_state;
  state_t              w_follow_state;
  logic                r_wait_first;
  logic [BYTE_W-1:0]   r_seq;
  logic [BYTE_W-1:0]   r_last_byte;
  logic [BYTE_W-1:0]   w_byte;
  logic [7:0]          r_sample_idx;
  logic                r_overrun;
  logic                w_byte_state;
  logic                w_strobe;
  logic                w_wait_done;
  logic                w_last_sample;
  logic                w_pop;
  logic                w_drop;
  logic [SAMPLE_W-1:0] w_head;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
`ifdef FRAME_CHECKSUM_EN
  logic [BYTE_W-1:0]   r_csum;
`endif

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.sample_valid),
    .i_data  (bus.sample),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_byte_state  = (r_state != ST_IDLE) && (r_state != ST_WAIT);
  assign w_strobe      = w_byte_state && !bus.uart_busy;
  // The first WAIT cycle covers the transmitter's busy-rise latency.
  assign w_wait_done   = (r_state == ST_WAIT) && !r_wait_first && !bus.uart_busy;
  assign w_last_sample = (r_sample_idx == 8'(SAMPLES_PER_FRAME - 1));
  assign w_pop         = w_strobe && (r_state == ST_LO) && !w_empty;
  assign w_drop        = bus.sample_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_follow_state = ST_IDLE;
    unique case (r_state)
      ST_SYNC: w_follow_state = ST_SEQ;
      ST_SEQ:  w_follow_state = ST_HI;
      ST_HI:   w_follow_state = ST_LO;
`ifdef FRAME_CHECKSUM_EN
      ST_LO:   w_follow_state = w_last_sample ? ST_CSUM : ST_HI;
`else
      ST_LO:   w_follow_state = w_last_sample ? ST_IDLE : ST_HI;
`endif
      default: w_follow_state = ST_IDLE;
    endcase

    unique case (r_state)
      ST_IDLE: if (bus.enable && w_count >= CW'(SAMPLES_PER_FRAME)) w_next_state = ST_SYNC;
      ST_WAIT: if (w_wait_done) w_next_state = r_ret_state;
      default: if (w_strobe) w_next_state = ST_WAIT;
    endcase
  end

  always_comb begin
    w_byte = r_last_byte;
    unique case (r_state)
      ST_SYNC: w_byte = SYNC_BYTE;
      ST_SEQ:  w_byte = r_seq;
      ST_HI:   w_byte = sample_hi_byte(w_head);
      ST_LO:   w_byte = w_head[BYTE_W-1:0];
`ifdef FRAME_CHECKSUM_EN
      ST_CSUM: w_byte = r_csum;
`endif
      default: w_byte = r_last_byte;
    endcase
    bus.uart_tx_en   = w_strobe;
    bus.uart_tx_data = w_strobe ? w_byte : r_last_byte;
    bus.frame_active = (r_state != ST_IDLE) && ((r_state != ST_SYNC) || w_strobe);
  end

  assign bus.overrun = r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ret_state  <= ST_IDLE;
      r_wait_first <= 1'b0;
      r_seq        <= '0;
      r_sample_idx <= '0;
      r_last_byte  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_wait_first <= w_strobe;
      if (w_drop) r_overrun <= 1'b1;
      if (w_strobe) begin
        r_last_byte <= w_byte;
        r_ret_state <= w_follow_state;
      end
      if (w_strobe && r_state == ST_SYNC) r_sample_idx <= '0;
      else if (w_pop)                     r_sample_idx <= r_sample_idx + 8'd1;
      if (w_wait_done && r_ret_state == ST_IDLE) r_seq <= r_seq + 8'd1;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_strobe) begin
      if (r_state == ST_SYNC) r_csum <= '0;
      else if (r_state == ST_SEQ || r_state == ST_HI || r_state == ST_LO) r_csum <= r_csum ^ w_byte;
    end
  end
`endif

endmodule
